// File: rtl/fft_pkg.sv
// Shared FFT defaults and the reader FSM state encoding.
package fft_pkg;

    localparam int unsigned FFT_SIZE = 64;
    localparam int unsigned FFT_DW   = 32;
    localparam int unsigned FFT_AW   = 6;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } fft_state_t;

endpackage

// File: rtl/spectrum_skid_buf.sv
// Two-entry valid/ready buffer carrying {data, bin, sof, eof}; occupancy feeds the read-issue logic.
module spectrum_skid_buf
    import fft_pkg::*;
#(
    parameter int unsigned DW = FFT_DW,
    parameter int unsigned AW = FFT_AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_push,
    input  logic [DW-1:0] i_data,
    input  logic [AW-1:0] i_bin,
    input  logic          i_sof,
    input  logic          i_eof,
    input  logic          i_ready,
    output logic          o_valid,
    output logic [DW-1:0] o_data,
    output logic [AW-1:0] o_bin,
    output logic          o_sof,
    output logic          o_eof,
    output logic [1:0]    o_occ
);

    localparam int unsigned W = DW + AW + 2;

    logic [W-1:0] r_head;
    logic [W-1:0] r_tail;
    logic [1:0]   r_occ;
    logic [W-1:0] w_in;
    logic         w_pop;

    assign w_in  = {i_data, i_bin, i_sof, i_eof};
    assign w_pop = (r_occ != 2'd0) && i_ready;

    // Push into a full buffer never happens: the reader only issues when a slot is guaranteed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_head <= '0;
            r_tail <= '0;
            r_occ  <= '0;
        end else begin
            case (r_occ)
                2'd0: begin
                    if (i_push) begin
                        r_head <= w_in;
                        r_occ  <= 2'd1;
                    end
                end
                2'd1: begin
                    case ({i_push, w_pop})
                        2'b11: r_head <= w_in;
                        2'b10: begin
                            r_tail <= w_in;
                            r_occ  <= 2'd2;
                        end
                        2'b01: r_occ <= 2'd0;
                        default: ;
                    endcase
                end
                2'd2: begin
                    if (w_pop) begin
                        r_head <= r_tail;
                        if (i_push) r_tail <= w_in;
                        else        r_occ  <= 2'd1;
                    end
                end
                default: r_occ <= 2'd0;
            endcase
        end
    end

    assign o_valid = (r_occ != 2'd0);
    assign {o_data, o_bin, o_sof, o_eof} = r_head;
    assign o_occ   = r_occ;

endmodule

// File: rtl/spectrum_reader.sv
// Streams one frame of FFT bin magnitudes from a 1-cycle-latency RAM onto a valid/ready port.
// Optional peak tracker enabled by defining PEAK_DETECT_EN.
module spectrum_reader
    import fft_pkg::*;
#(
    parameter int unsigned SIZE = FFT_SIZE,
    parameter int unsigned DW   = FFT_DW,
    parameter int unsigned AW   = FFT_AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          frame_rdy,
    output logic          frame_done,
    output logic          busy,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr,
    input  logic [DW-1:0] rd_data,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [DW-1:0] m_data,
    output logic [AW-1:0] m_bin,
    output logic          m_sof,
    output logic          m_eof,
    output logic [15:0]   frame_cnt
`ifdef PEAK_DETECT_EN
    ,
    output logic [DW-1:0] peak_mag,
    output logic [AW-1:0] peak_bin,
    output logic          peak_vld
`endif
);

    localparam logic [AW-1:0] LAST = AW'(SIZE - 1);

    fft_state_t    r_state;
    fft_state_t    w_next;
    logic [AW-1:0] r_cnt;
    logic [AW-1:0] r_addr;
    logic          r_infl;
    logic          r_done;
    logic [15:0]   r_frame_cnt;
    logic [1:0]    w_occ;
    logic          w_pop;
    logic [2:0]    w_level;
    logic          w_issue;
    logic          w_last_pop;

    spectrum_skid_buf #(
        .DW (DW),
        .AW (AW)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .i_push  (r_infl),
        .i_data  (rd_data),
        .i_bin   (r_addr),
        .i_sof   (r_addr == '0),
        .i_eof   (r_addr == LAST),
        .i_ready (m_ready),
        .o_valid (m_valid),
        .o_data  (m_data),
        .o_bin   (m_bin),
        .o_sof   (m_sof),
        .o_eof   (m_eof),
        .o_occ   (w_occ)
    );

    // Slots committed after this cycle's pop: buffered beats plus the read whose data lands next.
    assign w_pop      = m_valid && m_ready;
    assign w_level    = {1'b0, w_occ} + {2'b00, r_infl} - {2'b00, w_pop};
    assign w_issue    = (r_state == STREAM) && (w_level < 3'd2);
    assign w_last_pop = (r_state == DONE) && w_pop && m_eof;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (frame_rdy) w_next = STREAM;
            STREAM:  if (w_issue && (r_cnt == LAST)) w_next = DONE;
            DONE:    if (w_last_pop) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // rd_addr shows the issuing address, otherwise the last one issued, so it never passes SIZE-1.
    always_comb begin
        busy    = (r_state != IDLE);
        rd_en   = w_issue;
        rd_addr = w_issue ? r_cnt : r_addr;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt       <= '0;
            r_addr      <= '0;
            r_infl      <= 1'b0;
            r_done      <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            r_infl <= w_issue;
            r_done <= w_last_pop;
            if (r_state == IDLE) begin
                r_cnt  <= '0;
                r_addr <= '0;
            end else if (w_issue) begin
                r_cnt  <= r_cnt + AW'(1);
                r_addr <= r_cnt;
            end
            if (w_last_pop) r_frame_cnt <= r_frame_cnt + 16'd1;
        end
    end

    assign frame_done = r_done;
    assign frame_cnt  = r_frame_cnt;

`ifdef PEAK_DETECT_EN
    logic [DW-1:0] r_run_mag;
    logic [AW-1:0] r_run_bin;
    logic [DW-1:0] r_peak_mag;
    logic [AW-1:0] r_peak_bin;
    logic          r_peak_vld;
    logic          w_gt;

    // Sign bit ignored so -0 and +0 compare equal; strict compare keeps the lowest bin on ties.
    assign w_gt = m_data[DW-2:0] > r_run_mag[DW-2:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_run_mag  <= '0;
            r_run_bin  <= '0;
            r_peak_mag <= '0;
            r_peak_bin <= '0;
            r_peak_vld <= 1'b0;
        end else begin
            r_peak_vld <= w_last_pop;
            if (w_pop && (m_sof || w_gt)) begin
                r_run_mag <= m_data;
                r_run_bin <= m_bin;
            end
            if (w_last_pop) begin
                r_peak_mag <= w_gt ? m_data : r_run_mag;
                r_peak_bin <= w_gt ? m_bin : r_run_bin;
            end
        end
    end

    assign peak_mag = r_peak_mag;
    assign peak_bin = r_peak_bin;
    assign peak_vld = r_peak_vld;
`endif

endmodule

// File: tb/tb_spectrum_reader.sv
// Scoreboard bench for spectrum_reader: expected beats queued at frame start, popped on each accepted beat.
`timescale 1ns/1ps
module tb_spectrum_reader;

    localparam int SIZE = 64;
    localparam int DW   = 32;
    localparam int AW   = 6;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [AW-1:0] b;
        logic          s;
        logic          e;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          frame_rdy = 1'b0;
    logic          m_ready = 1'b0;
    logic          frame_done, busy, rd_en, m_valid, m_sof, m_eof;
    logic [AW-1:0] rd_addr, m_bin;
    logic [DW-1:0] rd_data, m_data;
    logic [15:0]   frame_cnt;
`ifdef PEAK_DETECT_EN
    logic [DW-1:0] peak_mag;
    logic [AW-1:0] peak_bin;
    logic          peak_vld;
`endif

    spectrum_reader #(.SIZE(SIZE), .DW(DW), .AW(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .frame_rdy  (frame_rdy),
        .frame_done (frame_done),
        .busy       (busy),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_bin      (m_bin),
        .m_sof      (m_sof),
        .m_eof      (m_eof),
        .frame_cnt  (frame_cnt)
`ifdef PEAK_DETECT_EN
        ,
        .peak_mag   (peak_mag),
        .peak_bin   (peak_bin),
        .peak_vld   (peak_vld)
`endif
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem [SIZE];
    always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int    n_checks = 0;
    int    n_errors = 0;
    beat_t exp_q[$];
    int    beats, reads, max_addr, n_done, done_cyc, first_valid_cyc;
    bit    seen_valid;
    bit    prev_stall;
    beat_t held;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic observe();
        beat_t cur;
        beat_t e;
        cur = {m_data, m_bin, m_sof, m_eof};
        if (prev_stall) begin
            check("stall_valid", m_valid, 1);
            check("stall_hold", cur, held);
        end
        if (m_valid && !seen_valid) begin
            seen_valid      = 1;
            first_valid_cyc = cyc;
        end
        if (m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
                check("extra_beat", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("beat_data", m_data, e.d);
                check("beat_tag", {m_bin, m_sof, m_eof}, {e.b, e.s, e.e});
            end
            beats++;
        end
        prev_stall = m_valid && !m_ready;
        held       = cur;
        if (rd_en) begin
            reads++;
            if (int'(rd_addr) > max_addr) max_addr = int'(rd_addr);
        end
        if (frame_done) begin
            n_done++;
            done_cyc = cyc;
            check("done_busy", busy, 0);
        end
`ifdef PEAK_DETECT_EN
        if (frame_done || peak_vld) check("peak_vld", peak_vld, frame_done);
`endif
    endtask

    task automatic step(input logic rdy, input logic frdy);
        @(posedge clk);
        #1;
        m_ready   = rdy;
        frame_rdy = frdy;
        @(negedge clk);
        observe();
    endtask

    task automatic push_frame();
        for (int i = 0; i < SIZE; i++)
            exp_q.push_back({mem[i], AW'(i), i == 0, i == SIZE - 1});
    endtask

    task automatic start_frame(input logic rdy, output int a);
        push_frame();
        seen_valid = 0;
        beats      = 0;
        reads      = 0;
        max_addr   = 0;
        step(rdy, 1'b1);
        a = cyc;
    endtask

    task automatic run_until_done(input int budget, input bit rnd);
        int n0;
        int k;
        logic r;
        n0 = n_done;
        k  = 0;
        while (n_done == n0 && k < budget) begin
            r = rnd ? ($urandom_range(0, 99) < 30) : 1'b1;
            step(r, 1'b0);
            k++;
        end
        check("done_timeout", n_done - n0, 1);
    endtask

    initial begin
        int a;
        int k;
        int n0;
        int d_prev;
        n_done = 0;
        prev_stall = 0;
        for (int i = 0; i < SIZE; i++) mem[i] = DW'(i);

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_outs", {frame_done, busy, rd_en, m_valid, m_sof, m_eof, rd_addr, m_bin,
                           m_data, frame_cnt}, 64'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        step(1'b1, 1'b0);

        // Test 1: full throughput
        start_frame(1'b1, a);
        run_until_done(200, 1'b0);
        check("t1_first_valid", first_valid_cyc - a, 3);
        check("t1_done_lat", done_cyc - a, 67);
        check("t1_beats", beats, SIZE);
        check("t1_reads", reads, SIZE);
        check("t1_cnt", frame_cnt, 1);
        check("t1_q_empty", exp_q.size(), 0);
        step(1'b1, 1'b0);
        check("t1_idle", busy, 0);

        // Test 2: random 30% ready
        start_frame(1'b0, a);
        run_until_done(2000, 1'b1);
        check("t2_beats", beats, SIZE);
        check("t2_reads", reads, SIZE);
        check("t2_max_addr", max_addr, SIZE - 1);
        check("t2_cnt", frame_cnt, 2);
        check("t2_q_empty", exp_q.size(), 0);

        // Test 3: long stall after first valid
        start_frame(1'b0, a);
        k = 0;
        while (!m_valid && k < 10) begin
            step(1'b0, 1'b0);
            k++;
        end
        check("t3_valid_seen", m_valid, 1);
        repeat (20) step(1'b0, 1'b0);
        check("t3_reads_le2", reads <= 2, 1);
        check("t3_addr_le1", (max_addr <= 1) && (rd_addr <= 1), 1);
        check("t3_q_untouched", exp_q.size(), SIZE);
        run_until_done(300, 1'b0);
        check("t3_beats", beats, SIZE);
        check("t3_cnt", frame_cnt, 3);

        // Test 4: reset mid-frame
        for (int i = 0; i < SIZE; i++) mem[i] = DW'(i * 3 + 32'h100);
        start_frame(1'b1, a);
        k = 0;
        while (beats < 30 && k < 100) begin
            step(1'b1, 1'b0);
            k++;
        end
        check("t4_reach30", beats, 30);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("t4_rst_outs", {frame_done, busy, rd_en, m_valid, m_sof, m_eof, rd_addr, m_bin,
                              m_data, frame_cnt}, 64'd0);
        exp_q.delete();
        prev_stall = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        n0 = n_done;
        repeat (80) step(1'b1, 1'b0);
        check("t4_no_done", n_done - n0, 0);
        check("t4_idle", busy, 0);
        start_frame(1'b1, a);
        run_until_done(200, 1'b0);
        check("t4_beats", beats, SIZE);
        check("t4_done_lat", done_cyc - a, 67);
        check("t4_cnt", frame_cnt, 1);

        // Test 5: back-to-back frames and counter wrap
        step(1'b1, 1'b0);
        @(posedge clk);
        #1 force dut.r_frame_cnt = 16'hFFFF;
        @(negedge clk);
        check("t5_forced", frame_cnt, 16'hFFFF);
        release dut.r_frame_cnt;
        push_frame();
        push_frame();
        push_frame();
        beats = 0;
        n0 = n_done;
        step(1'b1, 1'b1);
        a = cyc;
        d_prev = a;
        k = 0;
        while ((n_done - n0) < 3 && k < 400) begin
            step(1'b1, (n_done - n0) < 2);
            if (frame_done) begin
                check("t5_period", done_cyc - d_prev, 67);
                check("t5_cnt", frame_cnt, 16'(n_done - n0 - 1));
                d_prev = done_cyc;
            end
            k++;
        end
        check("t5_frames", n_done - n0, 3);
        check("t5_beats", beats, 3 * SIZE);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        check("t5_stopped", busy, 0);
        check("t5_q_empty", exp_q.size(), 0);

`ifdef PEAK_DETECT_EN
        // Test 6: peak tracking with a tie between bins 5 and 40
        for (int i = 0; i < SIZE; i++) mem[i] = 32'h3F80_0000;
        mem[5]  = 32'h42C8_0000;
        mem[40] = 32'h42C8_0000;
        start_frame(1'b1, a);
        run_until_done(200, 1'b0);
        check("t6_vld", peak_vld, 1);
        check("t6_bin", peak_bin, 5);
        check("t6_mag", peak_mag, 32'h42C8_0000);
        step(1'b1, 1'b0);
        check("t6_hold", {peak_vld, peak_bin, peak_mag}, {1'b0, 6'd5, 32'h42C8_0000});
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
        $fatal(1, "timeout");
    end

endmodule
